// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters.
// Optional per-requester grant counters are enabled with ALU_ARB_STATS_EN.

package alu_arbiter_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hA;
endpackage

module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] rd
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = rs2[SHW-1:0];

  // Unassigned op codes deliberately return zero.
  always_comb begin
    rd = '0;
    case (op)
      ALU_ADD:  rd = rs1 + rs2;
      ALU_SUB:  rd = rs1 - rs2;
      ALU_SLL:  rd = rs1 << shamt;
      ALU_SLT:  rd = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      ALU_SLTU: rd = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      ALU_XOR:  rd = rs1 ^ rs2;
      ALU_SRL:  rd = rs1 >> shamt;
      ALU_SRA:  rd = $unsigned($signed(rs1) >>> shamt);
      ALU_OR:   rd = rs1 | rs2;
      ALU_AND:  rd = rs1 & rs2;
      ALU_PASS: rd = rs2;
      default:  rd = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_rs1,
  input  logic [WIDTH*NREQ-1:0] req_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]    stat_grants
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_reg, state_next;

  logic [IDW-1:0]   last_grant_reg;
  logic [IDW-1:0]   id_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] rs1_reg, rs2_reg;
  logic [WIDTH-1:0] alu_rd;

  logic [3:0]       op_arr  [NREQ];
  logic [WIDTH-1:0] rs1_arr [NREQ];
  logic [WIDTH-1:0] rs2_arr [NREQ];

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_rs1, sel_rs2;
  int               cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi]  = req_op[4*gi +: 4];
      assign rs1_arr[gi] = req_rs1[WIDTH*gi +: WIDTH];
      assign rs2_arr[gi] = req_rs2[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(last_grant_reg) + 1 + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found && (j == cand) && req_valid[j]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(j);
        end
      end
    end
  end

  assign accept = !rst && (state_reg == IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_rs1   = '0;
    sel_rs2   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (j == int'(grant_idx)) begin
        req_ready[j] = accept;
        sel_op       = op_arr[j];
        sel_rs1      = rs1_arr[j];
        sel_rs2      = rs2_arr[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .op  (op_reg),
    .rs1 (rs1_reg),
    .rs2 (rs2_reg),
    .rd  (alu_rd)
  );

  // rsp_data/rsp_id keep their last values after the handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_id         <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
      id_reg         <= '0;
      op_reg         <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            op_reg         <= sel_op;
            rs1_reg        <= sel_rs1;
            rs2_reg        <= sel_rs2;
            id_reg         <= grant_idx;
            last_grant_reg <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data  <= alu_rd;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] grant_cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          grant_cnt_reg <= '0;
        end else if (accept && (int'(grant_idx) == gi) && (grant_cnt_reg != 16'hFFFF)) begin
          grant_cnt_reg <= grant_cnt_reg + 16'd1;
        end
      end
      assign stat_grants[16*gi +: 16] = grant_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected results into a
// scoreboard queue and a negedge monitor pops/compares on each response handshake.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_rs1 = '0;
  logic [WIDTH*NREQ-1:0] req_rs2 = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic [16*NREQ-1:0]    stat_grants;
`endif

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: one line per completed response.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h want no response", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp id=%0d data=%h (want id=%0d data=%h)", rsp_id, rsp_data, e.id, e.data);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]   = op;
    req_rs1[32*i +: 32] = a;
    req_rs2[32*i +: 32] = b;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got req_ready=0 want a grant");
    end
    g = req_ready;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] fair_g [4];
    int t_prev;
    int n;

    // Reset held with both requesters asking.
    rst = 1'b1;
    req_valid = 2'b11;
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_ADD, 32'd3, 32'd4);
    repeat (2) begin
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;

    // Single ADD from requester 0.
    set_req(0, ALU_ADD, 32'd10, 32'hFFFF_FFFB);
    req_valid = 2'b01;
    wait_grant(g);
    check("single_grant", 32'(g), 32'h1);
    sb.push_back('{id: 2'd0, data: 32'h0000_0005});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("single_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("single_resp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Fairness: last winner was 0, so requester 1 goes first, then alternation.
    set_req(0, ALU_SUB, 32'd10, 32'd10);
    set_req(1, ALU_SLL, 32'hbadc_affe, 32'd4);
    fair_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    req_valid = 2'b11;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check("fair_grant", 32'(g), 32'(fair_g[k]));
      if (k > 0) check("fair_spacing", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      if (fair_g[k] == 2'b10) sb.push_back('{id: 2'd1, data: 32'hadca_ffe0});
      else                    sb.push_back('{id: 2'd0, data: 32'h0000_0000});
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();

    // Backpressure: result held while consumer stalls; requester 1 waits.
    rsp_ready = 1'b0;
    set_req(0, ALU_XOR, 32'ha5a5_a5a5, 32'h5a5a_5a5a);
    set_req(1, ALU_ADD, 32'd1, 32'd2);
    req_valid = 2'b01;
    wait_grant(g);
    check("bp_grant", 32'(g), 32'h1);
    sb.push_back('{id: 2'd0, data: 32'hFFFF_FFFF});
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'hFFFF_FFFF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    sb.push_back('{id: 2'd1, data: 32'h0000_0003});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();

    // Reset during EXEC discards the operation and restores priority to 0.
    set_req(1, ALU_SRA, 32'ha5a5_a5a5, 32'd1);
    req_valid = 2'b10;
    wait_grant(g);
    check("rmo_grant", 32'(g), 32'h2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rmo_no_valid", 32'(rsp_valid), 32'd0);
    end
    check("rmo_rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #1;
    set_req(0, ALU_AND, 32'h0000_f0f0, 32'h0000_ff00);
    set_req(1, ALU_OR, 32'd1, 32'd2);
    req_valid = 2'b11;
    wait_grant(g);
    check("rmo_first_grant", 32'(g), 32'h1);
    sb.push_back('{id: 2'd0, data: 32'h0000_f000});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();

    // Three back-to-back grants to requester 1 alone.
    set_req(1, ALU_OR, 32'd1, 32'd2);
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      check("solo_grant", 32'(g), 32'h2);
      sb.push_back('{id: 2'd1, data: 32'h0000_0003});
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();
`ifdef ALU_ARB_STATS_EN
    check("stat_grants", stat_grants, {16'd3, 16'd1});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
